// File: rtl/nn_acc_ctrl.sv
// nn_acc_ctrl: accelerator-side responder for the CPU enable/done handshake.
// A rising edge on iACC_en runs one neuron. The neuron is a signed Q8.8 dot
// product of N_INPUTS words from the input memory and the weight memory. The
// saturated result goes to result memory, and then a one-cycle done pulse is
// sent.
// Optional feature macro: NN_ACC_RELU_EN (clamp negative results to zero).
module nn_acc_ctrl #(
    parameter int N_INPUTS = 16,
    parameter int ADDR_W   = 8,
    parameter int RES_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iACC_en,
    input  logic [ADDR_W-1:0] iInBase,
    output logic              oACC_done,
    output logic              oBusy,
    output logic              oMemRd,
    output logic [ADDR_W-1:0] oInAddr,
    output logic [ADDR_W-1:0] oWtAddr,
    input  logic [15:0]       iInData,
    input  logic [15:0]       iWtData,
    output logic              oResWr,
    output logic [ADDR_W-1:0] oResAddr,
    output logic [15:0]       oResData
);

    // idx reaches N_INPUTS (up to 256) on the last RUN edge, so it needs 9 bits
    localparam int IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

    state_t              state;
    logic                en_q;
    logic                start;
    logic                vld;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_inc;
    logic [ADDR_W-1:0]   base;
    logic signed [39:0]  acc;
    logic signed [31:0]  prod;
    logic signed [39:0]  acc_nxt;
    logic signed [39:0]  shr;
    logic [15:0]         res_sat;

    assign start    = iACC_en & ~en_q;
    assign idx_inc  = idx + 1'b1;
    assign oResAddr = ADDR_W'(RES_ADDR);

    // MAC datapath: 16x16 signed product, sign-extended into the 40-bit accumulator
    always_comb begin
        prod    = $signed(iInData) * $signed(iWtData);
        acc_nxt = acc + {{8{prod[31]}}, prod};
        shr     = acc_nxt >>> 8;
        res_sat = 16'h0000;
`ifdef NN_ACC_RELU_EN
        if (shr[39])
            res_sat = 16'h0000;
        else if (shr > 40'sd32767)
            res_sat = 16'h7FFF;
        else
            res_sat = shr[15:0];
`else
        if (shr > 40'sd32767)
            res_sat = 16'h7FFF;
        else if (shr < -40'sd32768)
            res_sat = 16'h8000;
        else
            res_sat = shr[15:0];
`endif
    end

    // Enable edge detector; reset leaves en_q low so an enable already high counts as a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= iACC_en;
    end

    // Control FSM with registered outputs; each branch sets the outputs for the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            vld       <= 1'b0;
            base      <= '0;
            oBusy     <= 1'b0;
            oMemRd    <= 1'b0;
            oInAddr   <= '0;
            oWtAddr   <= '0;
            oResWr    <= 1'b0;
            oResData  <= '0;
            oACC_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oACC_done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        idx     <= '0;
                        acc     <= '0;
                        vld     <= 1'b0;
                        base    <= iInBase;
                        oBusy   <= 1'b1;
                        oMemRd  <= 1'b1;
                        oInAddr <= iInBase;
                        oWtAddr <= '0;
                    end
                end
                RUN: begin
                    if (!iACC_en) begin
                        state   <= IDLE;
                        acc     <= '0;
                        vld     <= 1'b0;
                        oBusy   <= 1'b0;
                        oMemRd  <= 1'b0;
                        oInAddr <= '0;
                        oWtAddr <= '0;
                    end else begin
                        idx <= idx_inc;
                        vld <= 1'b1;
                        // data seen now belongs to the read issued one cycle earlier
                        if (vld) acc <= acc_nxt;
                        if (idx == LAST_IDX) begin
                            state   <= DRAIN;
                            oMemRd  <= 1'b0;
                            oInAddr <= '0;
                            oWtAddr <= '0;
                        end else begin
                            oInAddr <= base + ADDR_W'(idx_inc);
                            oWtAddr <= ADDR_W'(idx_inc);
                        end
                    end
                end
                DRAIN: begin
                    if (!iACC_en) begin
                        state <= IDLE;
                        acc   <= '0;
                        vld   <= 1'b0;
                        oBusy <= 1'b0;
                    end else begin
                        // last word arrives here; the result is formed from acc_nxt directly
                        state    <= WRITE;
                        acc      <= acc_nxt;
                        vld      <= 1'b0;
                        oResWr   <= 1'b1;
                        oResData <= res_sat;
                    end
                end
                WRITE: begin
                    // the write strobe is already out this cycle; only done is suppressed on abort
                    oResWr   <= 1'b0;
                    oResData <= '0;
                    if (!iACC_en) begin
                        state <= IDLE;
                        acc   <= '0;
                        oBusy <= 1'b0;
                    end else begin
                        state     <= DONE;
                        oACC_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    oACC_done <= 1'b0;
                    oBusy     <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    oBusy     <= 1'b0;
                    oMemRd    <= 1'b0;
                    oResWr    <= 1'b0;
                    oACC_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_acc_ctrl.sv
// Directed bench for nn_acc_ctrl with N_INPUTS=4 and synchronous-read memory models.
module tb_nn_acc_ctrl;

    localparam int N      = 4;
    localparam int AW     = 8;
    localparam int RES_A  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] in_base = '0;
    logic          done, busy, mem_rd, res_wr;
    logic [AW-1:0] in_addr, wt_addr, res_addr;
    logic [15:0]   in_data = '0, wt_data = '0, res_data;

    logic [15:0] in_mem [256];
    logic [15:0] wt_mem [256];

    int total = 0;
    int bad   = 0;

    nn_acc_ctrl #(.N_INPUTS(N), .ADDR_W(AW), .RES_ADDR(RES_A)) dut (
        .clk(clk), .rst_n(rst_n), .iACC_en(en), .iInBase(in_base),
        .oACC_done(done), .oBusy(busy), .oMemRd(mem_rd),
        .oInAddr(in_addr), .oWtAddr(wt_addr),
        .iInData(in_data), .iWtData(wt_data),
        .oResWr(res_wr), .oResAddr(res_addr), .oResData(res_data)
    );

    always #5 clk = ~clk;

    // one-cycle read latency memories
    always @(posedge clk) begin
        if (mem_rd) begin
            in_data <= in_mem[in_addr];
            wt_data <= wt_mem[wt_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] iv, input logic [15:0] wv);
        for (int i = 0; i < 256; i++) begin
            in_mem[i] = iv;
            wt_mem[i] = wv;
        end
    endtask

    // Called just after a clock edge with en low. Raises en; the next edge is cycle 0.
    task automatic run_chk(input string tag, input logic [AW-1:0] b, input logic [15:0] exp_res);
        int rd = 0, wr_c = -1, wr_n = 0, dn_c = -1, dn_n = 0, busy_n = 0, addr_bad = 0;
        logic [15:0]   rdat = '0;
        logic [AW-1:0] radr = '0;
        logic [AW-1:0] ea;
        in_base = b;
        en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= N + 6; c++) begin
            #1;
            if (mem_rd) begin
                ea = b + AW'(rd);
                if (in_addr !== ea || wt_addr !== AW'(rd)) addr_bad++;
                rd++;
            end
            if (res_wr) begin wr_c = c; wr_n++; rdat = res_data; radr = res_addr; end
            if (done) begin dn_c = c; dn_n++; end
            if (busy) busy_n++;
            @(posedge clk);
        end
        #1;
        chk({tag, ".rd_cnt"},   64'(rd),       64'(N));
        chk({tag, ".addr"},     64'(addr_bad), 64'd0);
        chk({tag, ".wr_cyc"},   64'(wr_c),     64'(N + 2));
        chk({tag, ".wr_n"},     64'(wr_n),     64'd1);
        chk({tag, ".res"},      64'(rdat),     64'(exp_res));
        chk({tag, ".res_addr"}, 64'(radr),     64'(RES_A));
        chk({tag, ".done_cyc"}, 64'(dn_c),     64'(N + 3));
        chk({tag, ".done_n"},   64'(dn_n),     64'd1);
        chk({tag, ".busy_n"},   64'(busy_n),   64'(N + 3));
    endtask

    task automatic drop_en;
        en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        int wr_n, dn_n, busy_n;
        fill(16'h0100, 16'h0200);

        // reset state
        #2;
        chk("rst.busy",     64'(busy),     64'd0);
        chk("rst.memrd",    64'(mem_rd),   64'd0);
        chk("rst.done",     64'(done),     64'd0);
        chk("rst.reswr",    64'(res_wr),   64'd0);
        chk("rst.res_addr", 64'(res_addr), 64'(RES_A));
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // nominal: 4 x (1.0 * 2.0) = 8.0
        run_chk("nom", 8'h10, 16'h0800);
        drop_en();

        // address wrap past 0xFF
        run_chk("wrap", 8'hFE, 16'h0800);
        drop_en();

        // mixed per-element values: 3 + 2 - 1 + 1 = 5.0
        in_mem[8'h20] = 16'h0100; wt_mem[0] = 16'h0300;
        in_mem[8'h21] = 16'h0200; wt_mem[1] = 16'h0100;
        in_mem[8'h22] = 16'hFF80; wt_mem[2] = 16'h0200;
        in_mem[8'h23] = 16'h0040; wt_mem[3] = 16'h0400;
        run_chk("mix", 8'h20, 16'h0500);
        drop_en();

        // positive saturation
        fill(16'h7FFF, 16'h7FFF);
        run_chk("sat", 8'h00, 16'h7FFF);
        drop_en();

        // negative: 4 x (-1.0 * 1.0) = -4.0
        fill(16'hFF00, 16'h0100);
`ifdef NN_ACC_RELU_EN
        run_chk("neg", 8'h00, 16'h0000);
`else
        run_chk("neg", 8'h00, 16'hFC00);
`endif
        drop_en();

        // negative saturation: 4 x (-128.0 * 127.99) clamps to 0x8000 (or 0 with ReLU)
        fill(16'h8000, 16'h7FFF);
`ifdef NN_ACC_RELU_EN
        run_chk("nsat", 8'h00, 16'h0000);
`else
        run_chk("nsat", 8'h00, 16'h8000);
`endif
        drop_en();

        // abort: en low in cycle 3
        fill(16'h0100, 16'h0200);
        en = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort.busy_c3", 64'(busy), 64'd1);
        en = 1'b0;
        @(posedge clk); #1;
        chk("abort.busy_c4", 64'(busy), 64'd0);
        wr_n = 0; dn_n = 0; busy_n = 0;
        for (int c = 0; c < 10; c++) begin
            if (res_wr) wr_n++;
            if (done) dn_n++;
            if (busy) busy_n++;
            @(posedge clk); #1;
        end
        chk("abort.wr",   64'(wr_n),   64'd0);
        chk("abort.done", 64'(dn_n),   64'd0);
        chk("abort.busy", 64'(busy_n), 64'd0);
        run_chk("after_abort", 8'h10, 16'h0800);

        // level hold: en stays high for 20 more cycles, no restart
        busy_n = 0; dn_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) busy_n++;
            if (done) dn_n++;
            @(posedge clk); #1;
        end
        chk("hold.busy", 64'(busy_n), 64'd0);
        chk("hold.done", 64'(dn_n),   64'd0);
        en = 1'b0;
        @(posedge clk); #1;
        run_chk("rearm", 8'h10, 16'h0800);
        drop_en();

        // async reset in RUN cycle 2
        en = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("arst.pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy",  64'(busy),    64'd0);
        chk("arst.memrd", 64'(mem_rd),  64'd0);
        chk("arst.addr",  64'(in_addr), 64'd0);
        chk("arst.wr",    64'(res_wr),  64'd0);
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.idle", 64'(busy), 64'd0);
        run_chk("post_rst", 8'h10, 16'h0800);
        drop_en();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: sim did not reach end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nn_acc_ctrl.md
# nn_acc_ctrl

Accelerator-side responder for the CPU's accelerator enable/done handshake. The CPU sets bit 3 of status register r15 to drive `iACC_en`. The done pulse from this block sets sticky bit 2 of r15. On each enable rising edge the block computes one neuron: a signed Q8.8 dot product of an input vector and a weight vector held in synchronous-read memories. It writes the saturated result to result memory, then pulses done.

## Interface
- `N_INPUTS`, 16: vector length; legal range 1..256.
- `ADDR_W`, 8: memory address width.
- `RES_ADDR`, 0: result memory write address.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iACC_en` in 1: level enable from r15[3].
- `iInBase` in ADDR_W: input vector base address, sampled at start.
- `oACC_done` out 1: one-cycle completion pulse to r15[2].
- `oBusy` out 1: high in any state except IDLE.
- `oMemRd` out 1: read strobe, shared by input and weight memories.
- `oInAddr` out ADDR_W: input memory address.
- `oWtAddr` out ADDR_W: weight memory address.
- `iInData` in 16: input word, valid the cycle after `oMemRd`.
- `iWtData` in 16: weight word, valid the cycle after `oMemRd`.
- `oResWr` out 1: result write strobe.
- `oResAddr` out ADDR_W: constant `RES_ADDR`.
- `oResData` out 16: result word.

## Operation
- `en_q` holds `iACC_en` registered each cycle; `start = iACC_en & ~en_q`.
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE -> RUN on `start`. On that edge: `idx <= 0`, `acc <= 0`, `base <= iInBase`, `vld <= 0`.
- RUN behaviour:
  - `oMemRd=1`, `oInAddr = base + idx` (wraps mod 2^ADDR_W), `oWtAddr = idx`.
  - Each edge: `idx++`, `vld <= 1`.
  - If `vld`, `acc += iInData * iWtData`.
  - Exit to DRAIN after the RUN cycle with `idx == N_INPUTS-1`.
- DRAIN: `oMemRd=0`; final MAC of the last word; -> WRITE.
- WRITE: `oResWr=1`, `oResData = sat16(relu(acc >>> 8))`; -> DONE.
- DONE: `oACC_done=1` for exactly one cycle; -> IDLE.
- Arithmetic:
  - Product is signed 16x16 -> 32 bits.
  - `acc` is 40-bit signed; no overflow is possible for N<=256.
  - Arithmetic shift right by 8.
  - Clamp to [0x8000, 0x7FFF] (signed).
- Abort: `iACC_en` low in RUN, DRAIN or WRITE -> IDLE on the next edge. No further `oResWr`, no `oACC_done`, `acc` cleared.
  - If `en` falls in the WRITE cycle, that write still completes and done is suppressed.
- No restart while `iACC_en` stays high after DONE; `en` must fall and rise again. The CPU clears r15[3] before re-arming.
- Reset (any state, async): state=IDLE, `idx=0`, `acc=0`, `vld=0`, `en_q=0`. All outputs 0, except `oResAddr` = `RES_ADDR`.
- `iACC_en` high at reset release counts as a rising edge on the first clock.

## Timing
- Start edge is cycle 0.
- RUN occupies cycles 1..N; `oMemRd` is high in exactly N cycles.
- DRAIN at N+1, WRITE at N+2, `oACC_done` at N+3.
- Enable-to-done latency is N+3 cycles; `oBusy` is high in cycles 1..N+3.
- Memory read latency is fixed at 1 cycle; no backpressure.
- Minimum re-trigger spacing: one cycle of `en` low after DONE, then a new rise.

## Configuration
- `NN_ACC_RELU_EN` defined:
  - Negative shifted results become 0 before saturation.
  - Output range is [0, 0x7FFF].
- `NN_ACC_RELU_EN` undefined:
  - No ReLU; signed saturated result is written.
  - Output range is [0x8000, 0x7FFF].

## Test plan
- Nominal (N_INPUTS=4, inputs 0x0100, weights 0x0200, base 0x10):
  - Reads at addresses 0x10..0x13.
  - `oResData=0x0800` with `oResWr` at cycle 6.
  - `oACC_done` pulses only at cycle 7.
- Saturation (N=4, all inputs and weights 0x7FFF) -> `oResData=0x7FFF`.
- Negative (N=4, inputs 0xFF00, weights 0x0100):
  - With `NN_ACC_RELU_EN`: `oResData=0x0000`.
  - Without it: `oResData=0xFC00`.
- Abort: drop `iACC_en` at cycle 3 -> `oBusy=0` from cycle 4, no `oResWr`, no `oACC_done`. A fresh rise then gives a correct result.
- Level hold: keep `iACC_en` high 20 cycles after done -> no second run. Lower for one cycle and raise -> new run, done N+3 cycles after the rise.
- Async reset at cycle 2 of RUN -> all outputs 0 immediately, state IDLE. Re-raising `en` yields a correct full run.
